led_pattern_gen: RTL and testbench

Parametrised successor to the board's fixed half-second LED blinker. It drives LED_NUM board LEDs from a registered pattern, which advances once per prescaler tick. Four runtime-selectable modes are supported: blink-all, walking-one, ping-pong and binary count. It also has pause and active-low output options. The block sits directly between the 27 MHz crystal clock domain and the LED pins.

---
 rtl/led_pattern_gen.sv | 101 ++++++++++
 tb/tb_led_pattern_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler paces a registered pattern through blink,
// walking-one, ping-pong or binary-count modes, with pause and optional inversion.
module led_pattern_gen #(
    parameter int CLOCK_XTAL = 27000000,
    parameter int TICK_HZ    = 2,
    parameter int LED_NUM    = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic               step_tick,
    output logic [LED_NUM-1:0] leds
);

    localparam int DIV = CLOCK_XTAL / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_BLINK = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_PING  = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    logic [PW-1:0]      prescaler;
    logic [LED_NUM-1:0] pattern;
    logic [LED_NUM-1:0] next_pattern;
    logic [LED_NUM-1:0] init_pattern;
    logic               dir;
    logic               next_dir;
    mode_t              act_mode;

    // Next pattern/direction for one step in the active mode
    always_comb begin
        next_pattern = pattern;
        next_dir     = dir;
        case (act_mode)
            MODE_BLINK: next_pattern = ~pattern;
            MODE_WALK:  next_pattern = {pattern[LED_NUM-2:0], pattern[LED_NUM-1]};
            MODE_PING: begin
                if (dir) begin
                    if (pattern[LED_NUM-1]) begin
                        next_dir     = 1'b0;
                        next_pattern = pattern >> 1;
                    end else begin
                        next_pattern = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        next_dir     = 1'b1;
                        next_pattern = pattern << 1;
                    end else begin
                        next_pattern = pattern >> 1;
                    end
                end
            end
            MODE_COUNT: next_pattern = pattern + 1'b1;
            default:    next_pattern = pattern;
        endcase
    end

    always_comb begin
        init_pattern = '0;
        if (mode == 2'd1 || mode == 2'd2) begin
            init_pattern = LED_NUM'(1);
        end
    end

    // A mode change outranks both pause and a coincident tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            act_mode  <= MODE_BLINK;
            pattern   <= '0;
            dir       <= 1'b1;
            step_tick <= 1'b0;
        end else if (mode != act_mode) begin
            act_mode  <= mode_t'(mode);
            prescaler <= '0;
            step_tick <= 1'b0;
            pattern   <= init_pattern;
            dir       <= 1'b1;
        end else if (pause) begin
            step_tick <= 1'b0;
        end else if (prescaler == LAST) begin
            prescaler <= '0;
            step_tick <= 1'b1;
            pattern   <= next_pattern;
            dir       <= next_dir;
        end else begin
            prescaler <= prescaler + 1'b1;
            step_tick <= 1'b0;
        end
    end

    assign leds = pattern ^ {LED_NUM{ACTIVE_LOW}};

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (DIV = 4, four active-low LEDs):
// expected ticks are queued with their cycle number and checked by a monitor.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       pause;
    logic       step_tick;
    logic [3:0] leds;

    typedef struct {
        int         cyc;
        logic [3:0] leds;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] pat_q[$];
    int         cyc;
    int         last_tick;
    int         tests;
    int         failures;

    led_pattern_gen #(
        .CLOCK_XTAL(8),
        .TICK_HZ   (2),
        .LED_NUM   (4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .pause    (pause),
        .step_tick(step_tick),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every tick must match the head of the scoreboard in cycle and value
    always @(negedge clk) begin
        if (!rst && step_tick) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected tick", 32'(leds), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("tick cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("tick leds", 32'(leds), 32'(e.leds));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input logic p);
        mode  = m;
        pause = p;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushTick(input int c, input logic [3:0] pat);
        exp_t e;
        e.cyc  = c;
        e.leds = ~pat;
        sb_q.push_back(e);
    endtask

    task automatic checkDrained(input string name);
        checkOutput({name, " pending ticks"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Switch mode, check the loaded init state, then queue the steps in pat_q
    task automatic runMode(input string name, input logic [1:0] m, input logic [3:0] init_pat);
        int         load;
        logic [3:0] init_leds;
        init_leds = ~init_pat;
        applyStimulus(m, 1'b0);
        load = cyc + 1;
        waitUntil(load);
        checkOutput({name, " init leds"}, 32'(leds), 32'(init_leds));
        checkOutput({name, " no tick on load"}, 32'(step_tick), 32'd0);
        for (int k = 0; k < pat_q.size(); k++) pushTick(load + 4 * (k + 1), pat_q[k]);
        last_tick = load + 4 * pat_q.size();
        pat_q.delete();
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int u;
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset leds", 32'(leds), 32'hF);
        checkOutput("reset tick", 32'(step_tick), 32'd0);
        rst = 1'b0;

        pushTick(4, 4'b1111);
        pushTick(8, 4'b0000);
        pushTick(12, 4'b1111);
        waitUntil(13);
        checkDrained("blink");

        pat_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        runMode("walk", 2'd1, 4'b0001);
        waitUntil(last_tick + 1);
        checkDrained("walk");

        pat_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        runMode("pingpong", 2'd2, 4'b0001);
        waitUntil(last_tick + 1);
        checkDrained("pingpong");

        for (int k = 1; k <= 17; k++) pat_q.push_back(4'(k));
        runMode("count", 2'd3, 4'b0000);
        waitUntil(last_tick + 1);
        checkDrained("count");

        waitUntil(last_tick + 3);
        pat_q = '{4'b0010, 4'b0100};
        runMode("switch", 2'd1, 4'b0001);
        waitUntil(last_tick + 1);
        checkDrained("switch");

        u = last_tick;
        waitUntil(u + 2);
        applyStimulus(2'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("pause leds", 32'(leds), 32'b1011);
            checkOutput("pause tick", 32'(step_tick), 32'd0);
        end
        applyStimulus(2'd1, 1'b0);
        pushTick(u + 14, 4'b1000);
        waitUntil(u + 15);
        checkDrained("resume");

        applyStimulus(2'd1, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        applyStimulus(2'd0, 1'b0);
        #1;
        checkOutput("async reset leds", 32'(leds), 32'hF);
        checkOutput("async reset tick", 32'(step_tick), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushTick(4, 4'b1111);
        pushTick(8, 4'b0000);
        waitUntil(9);
        checkDrained("post reset");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
